mcyc_ctrl: RTL and testbench

MCYC_CTRL -- requirements
Module: mcyc_ctrl

---
 rtl/mcyc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mcyc_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcyc_ctrl.sv
// mcyc_ctrl - multi-cycle instruction sequencing controller.
//
// Steps each instruction through IF -> ID -> EX -> [MEM] -> [WB] -> IF and
// drives the fetch/data request lines and the write strobes of a simple
// multi-cycle RV32-style datapath. The opcode class is captured in ID so the
// rest of the instruction is decided from the latched class only.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (overrides everything)
//   global_en  in   run enable; 0 freezes state, counters and all strobes
//   opcode     in   inst[6:0] from the external instruction register
//   imem_req   out  instruction fetch request (IF)
//   imem_rdy   in   fetch data valid this cycle
//   dmem_req   out  data access request (MEM)
//   dmem_we    out  data access is a store
//   dmem_rdy   in   data access complete this cycle
//   ir_we      out  load instruction register
//   pc_we      out  commit next PC
//   rf_we      out  register file write strobe
//   state      out  current state code (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   halted     out  controller is in HALT
//   illegal    out  HALT was caused by an unknown opcode
//   retired    out  retired-instruction count (wraps silently)
module mcyc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        global_en,
  input  logic [6:0]  opcode,
  output logic        imem_req,
  input  logic        imem_rdy,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_rdy,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_EBREAK = 7'b1110011;

  logic [2:0]  r_state;
  logic        r_illegal;
  logic [31:0] r_retired;
  logic        r_is_load;
  logic        r_is_store;

  logic [2:0]  w_next_state;
  logic        w_next_illegal;
  logic        w_retire;
  logic        w_active;
  logic        w_op_legal;
  logic        w_op_ebreak;
  logic        w_op_load;
  logic        w_op_store;

  // Opcode decode of the live instruction register; only consumed in ID.
  always_comb begin
    w_op_legal  = 1'b0;
    w_op_ebreak = 1'b0;
    w_op_load   = 1'b0;
    w_op_store  = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC: w_op_legal = 1'b1;
      OP_LOAD: begin
        w_op_legal = 1'b1;
        w_op_load  = 1'b1;
      end
      OP_STORE: begin
        w_op_legal = 1'b1;
        w_op_store = 1'b1;
      end
      OP_EBREAK: begin
        w_op_legal  = 1'b1;
        w_op_ebreak = 1'b1;
      end
      default: w_op_legal = 1'b0;
    endcase
  end

  // Next-state, illegal-flag and retire decisions.
  always_comb begin
    w_next_state   = r_state;
    w_next_illegal = r_illegal;
    w_retire       = 1'b0;
    case (r_state)
      S_IF: begin
        if (imem_rdy) w_next_state = S_ID;
        else          w_next_state = S_IF;
      end
      S_ID: begin
        if (w_op_ebreak) begin
          w_next_state = S_HALT;
        end else if (!w_op_legal) begin
          w_next_state   = S_HALT;
          w_next_illegal = 1'b1;
        end else begin
          w_next_state = S_EX;
        end
      end
      S_EX: begin
        if (r_is_load || r_is_store) w_next_state = S_MEM;
        else                         w_next_state = S_WB;
      end
      S_MEM: begin
        if (dmem_rdy) begin
          // Stores commit straight from MEM; loads still need WB.
          if (r_is_store) begin
            w_next_state = S_IF;
            w_retire     = 1'b1;
          end else begin
            w_next_state = S_WB;
          end
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_WB: begin
        w_next_state = S_IF;
        w_retire     = 1'b1;
      end
      S_HALT: w_next_state = S_HALT;
      default: begin
        // Unused codes 6/7 are treated as a corrupted state.
        w_next_state   = S_HALT;
        w_next_illegal = 1'b1;
      end
    endcase
  end

  // State, class, illegal and retired registers; frozen while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IF;
      r_illegal  <= 1'b0;
      r_retired  <= 32'd0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
    end else if (global_en) begin
      r_state   <= w_next_state;
      r_illegal <= w_next_illegal;
      if (w_retire) r_retired <= r_retired + 32'd1;
      else          r_retired <= r_retired;
      // Class is captured only in ID so later opcode changes are ignored.
      if (r_state == S_ID) begin
        r_is_load  <= w_op_load;
        r_is_store <= w_op_store;
      end else begin
        r_is_load  <= r_is_load;
        r_is_store <= r_is_store;
      end
    end else begin
      r_state    <= r_state;
      r_illegal  <= r_illegal;
      r_retired  <= r_retired;
      r_is_load  <= r_is_load;
      r_is_store <= r_is_store;
    end
  end

  // Requests and strobes: gated by enable, and forced low during reset
  // because reset is sampled only at the next edge.
  always_comb begin
    w_active = global_en & ~rst;
    imem_req = w_active & (r_state == S_IF);
    ir_we    = w_active & (r_state == S_IF) & imem_rdy;
    dmem_req = w_active & (r_state == S_MEM);
    dmem_we  = w_active & (r_state == S_MEM) & r_is_store;
    pc_we    = w_active & ((r_state == S_WB) |
                           ((r_state == S_MEM) & r_is_store & dmem_rdy));
    rf_we    = w_active & (r_state == S_WB);
    state    = rst ? S_IF : r_state;
    halted   = ~rst & (r_state == S_HALT);
    illegal  = ~rst & r_illegal;
    retired  = rst ? 32'd0 : r_retired;
  end

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Testbench for mcyc_ctrl: directed scenarios followed by randomized
// stimulus, every cycle compared against an instruction-level phase model.
module tb_mcyc_ctrl;

  logic        clk;
  logic        rst;
  logic        global_en;
  logic [6:0]  opcode;
  logic        imem_req;
  logic        imem_rdy;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_rdy;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  int n_cmp;
  int n_err;
  int cyc;

  // Reference model: the phases still ahead for the current instruction.
  int          m_ph[$];
  bit          m_store;
  bit          m_ill;
  logic [31:0] m_ret;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_EBREAK = 7'b1110011;

  mcyc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .global_en (global_en),
    .opcode    (opcode),
    .imem_req  (imem_req),
    .imem_rdy  (imem_rdy),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_rdy  (dmem_rdy),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .state     (state),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // 0 ALU-type, 1 load, 2 store, 3 ebreak, 4 unknown
  function automatic int op_class(input logic [6:0] op);
    if (op == OP_R || op == OP_I || op == OP_LUI || op == OP_AUIPC) return 0;
    if (op == OP_LOAD)   return 1;
    if (op == OP_STORE)  return 2;
    if (op == OP_EBREAK) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_ph    = '{0, 1};
    m_store = 1'b0;
    m_ill   = 1'b0;
    m_ret   = 32'd0;
  endtask

  // Drive one cycle (called at a falling edge), check, then advance the model.
  task automatic step(input logic a_rst, input logic a_en, input logic a_irdy,
                      input logic a_drdy, input logic [6:0] a_op);
    int p;
    bit act;
    bit done;
    int c;
    logic [7:0] exp_ctl;
    rst = a_rst; global_en = a_en; imem_rdy = a_irdy; dmem_rdy = a_drdy; opcode = a_op;
    #1;
    p   = m_ph[0];
    act = a_en && !a_rst;
    exp_ctl[7] = act && p == 0;
    exp_ctl[6] = act && p == 3;
    exp_ctl[5] = act && p == 3 && m_store;
    exp_ctl[4] = act && p == 0 && a_irdy;
    exp_ctl[3] = act && (p == 4 || (p == 3 && m_store && a_drdy));
    exp_ctl[2] = act && p == 4;
    exp_ctl[1] = !a_rst && p == 5;
    exp_ctl[0] = !a_rst && m_ill;
    check("state", {29'd0, state}, a_rst ? 32'd0 : p);
    check("ctl", {24'd0, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, illegal},
          {24'd0, exp_ctl});
    check("retired", retired, a_rst ? 32'd0 : m_ret);
    @(posedge clk);
    cyc++;
    if (a_rst) begin
      model_reset();
    end else if (a_en) begin
      done = (p == 0) ? a_irdy : (p == 3) ? a_drdy : (p == 5) ? 1'b0 : 1'b1;
      if (done) begin
        void'(m_ph.pop_front());
        if (p == 1) begin
          c = op_class(a_op);
          m_store = (c == 2);
          case (c)
            0: begin m_ph.push_back(2); m_ph.push_back(4); end
            1: begin m_ph.push_back(2); m_ph.push_back(3); m_ph.push_back(4); end
            2: begin m_ph.push_back(2); m_ph.push_back(3); end
            3: m_ph.push_back(5);
            default: begin m_ph.push_back(5); m_ill = 1'b1; end
          endcase
        end
        if (m_ph.size() == 0) begin
          m_ret = m_ret + 32'd1;
          m_ph  = '{0, 1};
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [6:0] pick_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 3)  return OP_R;
    if (r < 6)  return OP_I;
    if (r < 8)  return OP_LUI;
    if (r < 10) return OP_AUIPC;
    if (r < 14) return OP_LOAD;
    if (r < 18) return OP_STORE;
    if (r == 18) return OP_EBREAK;
    return 7'($urandom);
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1; global_en = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0; opcode = 7'd0;
    model_reset();
    @(negedge clk);

    // Reset with enable and handshakes active: everything low.
    step(1'b1, 1'b1, 1'b1, 1'b1, OP_R);
    step(1'b1, 1'b1, 1'b1, 1'b1, OP_R);

    // R-type with immediate fetch: 0,1,2,4 then back to 0.
    step(1'b0, 1'b1, 1'b1, 1'b0, OP_R);
    step(1'b0, 1'b1, 1'b1, 1'b0, OP_R);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_R);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_R);
    check("r_retired1", retired, 32'd1);
    check("r_back_if", {29'd0, state}, 32'd0);

    // LOAD, dmem_rdy after 3 wait cycles, opcode changed to STORE after ID.
    step(1'b0, 1'b1, 1'b1, 1'b1, OP_LOAD);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_LOAD);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_STORE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, OP_STORE);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_STORE);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_STORE);
    check("load_retired", retired, 32'd2);

    // STORE with dmem_rdy already high: commits from MEM, no rf_we.
    step(1'b0, 1'b1, 1'b1, 1'b1, OP_STORE);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_STORE);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_STORE);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_STORE);
    check("store_retired", retired, 32'd3);

    // Freeze 5 cycles in MEM with dmem_rdy high, then resume.
    step(1'b0, 1'b1, 1'b1, 1'b0, OP_LOAD);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_LOAD);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_LOAD);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, OP_LOAD);
    check("frozen_mem", {29'd0, state}, 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b1, OP_LOAD);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_LOAD);
    check("frozen_retired", retired, 32'd4);

    // Preload the counter to all-ones and retire one instruction.
    force dut.r_retired = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b0, 1'b0, OP_I);
    release dut.r_retired;
    step(1'b0, 1'b0, 1'b0, 1'b0, OP_I);
    step(1'b0, 1'b1, 1'b1, 1'b0, OP_I);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_I);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_I);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_I);
    check("wrap_retired", retired, 32'd0);

    // Reset in the middle of MEM with dmem_rdy high: abandoned, no strobe.
    step(1'b0, 1'b1, 1'b1, 1'b0, OP_STORE);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_STORE);
    step(1'b0, 1'b1, 1'b0, 1'b0, OP_STORE);
    step(1'b1, 1'b1, 1'b1, 1'b1, OP_STORE);
    check("rst_mid_mem", {29'd0, state}, 32'd0);

    // Unknown opcode halts with illegal set; HALT ignores fetch ready.
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'h7F);
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'h7F);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, OP_R);
    check("illegal_flag", {31'd0, illegal}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, OP_R);

    // EBREAK halts with illegal clear.
    step(1'b0, 1'b1, 1'b1, 1'b0, OP_EBREAK);
    step(1'b0, 1'b1, 1'b1, 1'b0, OP_EBREAK);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, OP_R);
    check("ebreak_halt", {30'd0, halted, illegal}, 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, OP_R);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      logic r_rst;
      if (m_ph[0] == 5) r_rst = ($urandom_range(0, 2) == 0);
      else              r_rst = ($urandom_range(0, 59) == 0);
      step(r_rst, $urandom_range(0, 99) < 85, 1'($urandom), 1'($urandom), pick_op());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
